// File: rtl/vector_capture.sv
// Test-vector recorder: captures WIDTH-bit samples between start/stop (or until full)
// and drains them in capture order over a valid/ready port. Optional feature: VCAP_OVERFLOW_EN.
module vector_capture #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic                    i_sample_valid,
   input  logic [WIDTH-1:0]        i_sample_data,
   output logic                    o_rd_valid,
   input  logic                    i_rd_ready,
   output logic [WIDTH-1:0]        o_rd_data,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_busy,
   output logic                    o_full,
   output logic                    o_done,
`ifdef VCAP_OVERFLOW_EN
   output logic                    o_overflow,
`endif
   output logic [1:0]              o_dbg_state
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_rd_ptr;
   logic [ADDR_W:0]     r_count;
   logic [WIDTH-1:0]    r_mem [DEPTH];

   logic                w_start_ok;
   logic                w_wr_en;
   logic                w_fill_last;
   logic                w_rd_valid;
   logic                w_rd_fire;
   logic                w_last_rd;

   // Handshake: a word moves on every edge where o_rd_valid && i_rd_ready;
   // o_rd_valid/o_rd_data depend only on registered state, never on i_rd_ready.
   assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_wr_en     = (r_state == S_CAPTURE) && i_sample_valid;
   assign w_fill_last = w_wr_en && (r_count == (C_DEPTH - C_ONE));
   assign w_rd_valid  = (r_state == S_DRAIN) && (r_rd_ptr != r_count);
   assign w_rd_fire   = w_rd_valid && i_rd_ready;
   assign w_last_rd   = w_rd_fire && ((r_rd_ptr + C_ONE) == r_count);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_rd_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            o_busy = 1'b1;
            // A sample accompanying stop is still written on the same edge.
            if (i_stop || w_fill_last) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            o_busy     = 1'b1;
            o_rd_valid = w_rd_valid;
            if ((r_count == '0) || w_last_rd) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            o_done = 1'b1;
            if (i_start) begin
               w_next_state = S_CAPTURE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // wr_ptr tracks count; it may wrap on the final write, but capture ends on that edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_start_ok) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + C_ONE;
         end
         if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en && !i_reset) begin
         r_mem[r_wr_ptr] <= i_sample_data;
      end
   end

   assign o_rd_data   = w_rd_valid ? r_mem[r_rd_ptr[ADDR_W-1:0]] : '0;
   assign o_count     = r_count;
   assign o_full      = (r_count == C_DEPTH);
   assign o_dbg_state = r_state;

`ifdef VCAP_OVERFLOW_EN
   logic r_overflow;

   // Sticky: a sample offered after a full capture has already ended.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_overflow <= 1'b0;
      end else if (w_start_ok) begin
         r_overflow <= 1'b0;
      end else if (i_sample_valid && o_full &&
                   ((r_state == S_DRAIN) || (r_state == S_DONE))) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_vector_capture.sv
// Bench for vector_capture: queue-based reference model of captured words, directed
// scenarios plus randomized runs. Honours VCAP_OVERFLOW_EN when defined.
module tb_vector_capture;

   localparam int WIDTH = 4;
   localparam int DEPTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic             sample_valid;
   logic [WIDTH-1:0] sample_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count;
   logic             busy;
   logic             full;
   logic             done;
   logic [1:0]       dbg_state;
`ifdef VCAP_OVERFLOW_EN
   logic             overflow;
   bit               exp_ovf;
`endif

   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] stim_q[$];
   int               run_cnt;

   vector_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_start        (start),
      .i_stop         (stop),
      .i_sample_valid (sample_valid),
      .i_sample_data  (sample_data),
      .o_rd_valid     (rd_valid),
      .i_rd_ready     (rd_ready),
      .o_rd_data      (rd_data),
      .o_count        (count),
      .o_busy         (busy),
      .o_full         (full),
      .o_done         (done),
`ifdef VCAP_OVERFLOW_EN
      .o_overflow     (overflow),
`endif
      .o_dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
      end
   endtask

   task automatic start_run();
      stop = 1'b0;
      sample_valid = 1'b0;
      rd_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.delete();
      run_cnt = 0;
`ifdef VCAP_OVERFLOW_EN
      exp_ovf = 1'b0;
      check("start_overflow", 32'(overflow), 32'(exp_ovf));
`endif
      check("start_busy", 32'(busy), 32'(1));
      check("start_done", 32'(done), 32'(0));
      check("start_count", 32'(count), 32'(0));
   endtask

   task automatic fill_random(input int n);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(WIDTH'($urandom));
   endtask

   // Offers every word of stim_q (with optional idle gaps); stops on the last one if asked.
   task automatic capture_run(input bit stop_last, input int gap_pct);
      bit ended;
      ended = 1'b0;
      for (int i = 0; i < stim_q.size() && !ended; i++) begin
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            sample_valid = 1'b0;
            sample_data  = WIDTH'($urandom);
            stop         = 1'b0;
            start        = 1'($urandom_range(0, 1));
            tick();
            check("gap_count", 32'(count), 32'(exp_q.size()));
            check("gap_busy", 32'(busy), 32'(1));
         end
         sample_valid = 1'b1;
         sample_data  = stim_q[i];
         stop         = stop_last && (i == stim_q.size() - 1);
         start        = 1'($urandom_range(0, 3) == 0);
         tick();
         exp_q.push_back(stim_q[i]);
         if (stop || exp_q.size() == DEPTH) ended = 1'b1;
         check("cap_count", 32'(count), 32'(exp_q.size()));
         check("cap_full", 32'(full), 32'(exp_q.size() == DEPTH));
         check("cap_busy", 32'(busy), 32'(1));
      end
      if (stim_q.size() == 0 && stop_last) begin
         sample_valid = 1'b0;
         stop = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      stop = 1'b0;
      start = 1'b0;
      run_cnt = exp_q.size();
   endtask

   // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1.
   // max_pops > 0 abandons the drain after that many transfers.
   task automatic drain_run(input int mode, input int max_pops, input bit noise);
      int guard;
      int pops;
      bit active;
      bit rdy;
      bit was_empty;
      bit sv;
      guard = 0;
      pops = 0;
      active = 1'b1;
      while (active && guard < 400) begin
         check("drain_busy", 32'(busy), 32'(1));
         check("drain_done", 32'(done), 32'(0));
         check("drain_rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("drain_rd_data", 32'(rd_data), 32'(exp_q[0]));
         check("drain_count", 32'(count), 32'(run_cnt));
`ifdef VCAP_OVERFLOW_EN
         check("drain_overflow", 32'(overflow), 32'(exp_ovf));
`endif
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (guard % 4 == 0) || (guard % 4 == 3);
         endcase
         rd_ready = rdy;
         sv = 1'b0;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            sv    = 1'($urandom_range(0, 1));
            sample_data = WIDTH'($urandom);
         end
         sample_valid = sv;
         was_empty = (exp_q.size() == 0);
         tick();
`ifdef VCAP_OVERFLOW_EN
         if (sv && run_cnt == DEPTH) exp_ovf = 1'b1;
`endif
         guard++;
         if (was_empty) begin
            active = 1'b0;
         end else if (rdy) begin
            void'(exp_q.pop_front());
            pops++;
            if (exp_q.size() == 0) active = 1'b0;
            if (max_pops > 0 && pops == max_pops) break;
         end
      end
      start = 1'b0;
      stop = 1'b0;
      sample_valid = 1'b0;
      rd_ready = 1'b0;
      if (max_pops == 0) begin
         check("drain_finished", 32'(active), 32'(0));
         check("done_done", 32'(done), 32'(1));
         check("done_busy", 32'(busy), 32'(0));
         check("done_rd_valid", 32'(rd_valid), 32'(0));
         check("done_count", 32'(count), 32'(run_cnt));
         check("done_full", 32'(full), 32'(run_cnt == DEPTH));
         tick();
         check("done_hold", 32'(done), 32'(1));
`ifdef VCAP_OVERFLOW_EN
         check("done_overflow", 32'(overflow), 32'(exp_ovf));
`endif
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
      check({tag, "_rd_data"}, 32'(rd_data), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_done"}, 32'(done), 32'(0));
      check({tag, "_full"}, 32'(full), 32'(0));
      check({tag, "_count"}, 32'(count), 32'(0));
`ifdef VCAP_OVERFLOW_EN
      check({tag, "_overflow"}, 32'(overflow), 32'(0));
`endif
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      sample_valid = 1'b0;
      sample_data = '0;
      rd_ready = 1'b0;
      run_cnt = 0;
`ifdef VCAP_OVERFLOW_EN
      exp_ovf = 1'b0;
`endif

      // Reset held for two cycles.
      tick();
      tick();
      check_reset_state("reset");
      reset = 1'b0;
      tick();
      check_reset_state("idle");

      // Three words, stop with the last, drain at full rate.
      start_run();
      stim_q = '{4'hA, 4'h3, 4'h5};
      capture_run(1'b1, 0);
      check("t2_count", 32'(count), 32'(3));
      drain_run(0, 0, 1'b0);

      // Fill to DEPTH with no stop, then offer one more sample.
      start_run();
      stim_q.delete();
      for (int i = 0; i < DEPTH; i++) stim_q.push_back(WIDTH'(i));
      capture_run(1'b0, 0);
      check("t3_full", 32'(full), 32'(1));
      check("t3_busy", 32'(busy), 32'(1));
      check("t3_count", 32'(count), 32'(DEPTH));
      sample_valid = 1'b1;
      sample_data = 4'hF;
      tick();
      sample_valid = 1'b0;
`ifdef VCAP_OVERFLOW_EN
      exp_ovf = 1'b1;
      check("t3_overflow", 32'(overflow), 32'(1));
`endif
      check("t3_count_after", 32'(count), 32'(DEPTH));
      check("t3_rd_data_first", 32'(rd_data), 32'(0));
      drain_run(0, 0, 1'b0);

      // Backpressure with ready pattern 1,0,0,1.
      start_run();
      fill_random(6);
      capture_run(1'b1, 30);
      drain_run(2, 0, 1'b0);

      // Stop with no samples, then a clean restart from DONE.
      start_run();
      stim_q.delete();
      capture_run(1'b1, 0);
      check("t5_count", 32'(count), 32'(0));
      check("t5_rd_valid", 32'(rd_valid), 32'(0));
      drain_run(0, 0, 1'b0);
      start_run();
      fill_random(2);
      capture_run(1'b1, 0);
      drain_run(1, 0, 1'b0);

      // Reset after two of four words have drained.
      start_run();
      fill_random(4);
      capture_run(1'b1, 0);
      drain_run(0, 2, 1'b0);
      check("t6_remaining", 32'(rd_valid), 32'(1));
      check("t6_next_word", 32'(rd_data), 32'(exp_q[0]));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
`ifdef VCAP_OVERFLOW_EN
      exp_ovf = 1'b0;
`endif
      check_reset_state("t6_reset");
      start_run();
      fill_random(5);
      capture_run(1'b1, 20);
      drain_run(1, 0, 1'b1);

      // Randomized runs, including runs that fill and overrun the memory.
      for (int r = 0; r < 10; r++) begin
         start_run();
         n = int'($urandom_range(0, DEPTH + 2));
         fill_random(n);
         capture_run(n <= DEPTH, 25);
         drain_run(1, 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
